// File: rtl/stream_transpose_pkg.sv
// Shared types and sizing helpers for the streaming tile transpose.
package stream_transpose_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

    // Pointer width for a counter spanning 0..n-1, never narrower than one bit.
    function automatic int idx_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/stream_transpose_bank.sv
// One ROWS x COLS element matrix: written a row at a time, read a column at a time.
module transpose_bank
    import stream_transpose_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ROWS   = 28,
    parameter int COLS   = 11
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [idx_w(ROWS)-1:0]      wr_row,
    input  logic [COLS*DATA_W-1:0]      wr_data,
    input  logic [idx_w(COLS)-1:0]      rd_col,
    output logic [ROWS*DATA_W-1:0]      rd_data
);

    logic [COLS*DATA_W-1:0] mem_r [ROWS];

    // Row write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[wr_row] <= wr_data;
        end
    end

    // Column gather across all rows.
    always_comb begin
        rd_data = '0;
        for (int r = 0; r < ROWS; r++) begin
            rd_data[r*DATA_W +: DATA_W] = mem_r[r][int'(rd_col)*DATA_W +: DATA_W];
        end
    end

endmodule

// File: rtl/stream_transpose.sv
// Streaming ROWS x COLS transpose; define STREAM_TRANSPOSE_PINGPONG_EN to build a
// second bank so the next tile can load while the current one drains.
module stream_transpose
    import stream_transpose_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ROWS   = 28,
    parameter int COLS   = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [COLS*DATA_W-1:0] in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ROWS*DATA_W-1:0] out_data,
    output logic                   out_last,
    output logic                   err_frame
);

    localparam int RW = idx_w(ROWS);
    localparam int CW = idx_w(COLS);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
`ifdef STREAM_TRANSPOSE_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic [RW-1:0]          wr_row_r;
    logic [CW-1:0]          rd_col_r;
    bank_state_t            bank_state_r [NB];
    logic                   err_frame_r;
    logic                   wr_bank_s;
    logic                   rd_bank_s;
    bank_state_t            wr_state_s;
    bank_state_t            rd_state_s;
    logic                   wr_fire_s;
    logic                   rd_fire_s;
    logic                   wr_done_s;
    logic                   rd_done_s;
    logic [ROWS*DATA_W-1:0] bank_col_s [NB];

    for (genvar b = 0; b < NB; b++) begin : g_bank
        transpose_bank #(
            .DATA_W (DATA_W),
            .ROWS   (ROWS),
            .COLS   (COLS)
        ) u_bank (
            .clk     (clk),
            .we      (wr_fire_s && (wr_bank_s == 1'(b))),
            .wr_row  (wr_row_r),
            .wr_data (in_data),
            .rd_col  (rd_col_r),
            .rd_data (bank_col_s[b])
        );
    end

`ifdef STREAM_TRANSPOSE_PINGPONG_EN
    logic wr_bank_r;
    logic rd_bank_r;

    // Bank selectors flip as their bank completes a fill or a drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_r <= 1'b0;
            rd_bank_r <= 1'b0;
        end else begin
            if (wr_done_s) wr_bank_r <= ~wr_bank_r;
            if (rd_done_s) rd_bank_r <= ~rd_bank_r;
        end
    end

    assign wr_bank_s = wr_bank_r;
    assign rd_bank_s = rd_bank_r;

    // Route the selected banks to the handshake and the output port.
    always_comb begin
        wr_state_s = bank_state_r[wr_bank_r];
        rd_state_s = bank_state_r[rd_bank_r];
        out_data   = bank_col_s[rd_bank_r];
    end
`else
    assign wr_bank_s = 1'b0;
    assign rd_bank_s = 1'b0;

    // Single bank serves both sides, so load and drain strictly alternate.
    always_comb begin
        wr_state_s = bank_state_r[0];
        rd_state_s = bank_state_r[0];
        out_data   = bank_col_s[0];
    end
`endif

    // Handshake and end-of-fill / end-of-drain detection.
    always_comb begin
        in_ready  = (wr_state_s != FULL);
        out_valid = (rd_state_s == FULL);
        out_last  = out_valid && (rd_col_r == COL_LAST);
        wr_fire_s = in_valid && in_ready;
        rd_fire_s = out_valid && out_ready;
        wr_done_s = wr_fire_s && (wr_row_r == ROW_LAST);
        rd_done_s = rd_fire_s && (rd_col_r == COL_LAST);
    end

    // Pointers, bank states and the sticky framing flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_row_r    <= '0;
            rd_col_r    <= '0;
            err_frame_r <= 1'b0;
            for (int b = 0; b < NB; b++) begin
                bank_state_r[b] <= EMPTY;
            end
        end else begin
            if (wr_fire_s) begin
                wr_row_r <= wr_done_s ? '0 : wr_row_r + RW'(1);
            end
            if (rd_fire_s) begin
                rd_col_r <= rd_done_s ? '0 : rd_col_r + CW'(1);
            end
            // in_last must coincide exactly with the final row; framing never alters data flow.
            if (wr_fire_s && (in_last != (wr_row_r == ROW_LAST))) begin
                err_frame_r <= 1'b1;
            end
            for (int b = 0; b < NB; b++) begin
                if (wr_fire_s && (wr_bank_s == 1'(b))) begin
                    bank_state_r[b] <= wr_done_s ? FULL : FILLING;
                end else if (rd_done_s && (rd_bank_s == 1'(b))) begin
                    bank_state_r[b] <= EMPTY;
                end
            end
        end
    end

    assign err_frame = err_frame_r;

endmodule

// File: tb/tb_stream_transpose.sv
// Self-checking bench for stream_transpose (ROWS=4, COLS=3, DATA_W=16).
module tb_stream_transpose;

    localparam int DATA_W = 16;
    localparam int ROWS   = 4;
    localparam int COLS   = 3;
    localparam int IW     = COLS * DATA_W;
    localparam int OW     = ROWS * DATA_W;
`ifdef STREAM_TRANSPOSE_PINGPONG_EN
    localparam logic PP = 1'b1;
`else
    localparam logic PP = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic          out_last;
    logic          err_frame;

    stream_transpose #(.DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .err_frame (err_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [IW-1:0] mrows [ROWS];
    int            mcnt = 0;
    logic [OW-1:0] exp_q [$];
    logic          exp_last_q [$];
    int            out_beats = 0;

    logic          s_in_ready, s_out_valid, s_out_last, s_err;
    logic [OW-1:0] s_out_data;
    logic          in_fire;

    typedef struct {
        logic          iv;
        int            row;
        logic          il;
        logic          ordy;
        logic          x_in_ready;
        logic          x_out_valid;
        logic          x_out_last;
        logic [OW-1:0] x_out_data;
        logic          x_err;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] row_data(input int t, input int r);
        logic [IW-1:0] d;
        for (int c = 0; c < COLS; c++) begin
            d[c*DATA_W +: DATA_W] = 16'(256 * t + r * 16 + c);
        end
        return d;
    endfunction

    // One clock: drive at posedge+1, sample at negedge, score handshakes.
    task automatic cycle(input logic iv, input logic [IW-1:0] d, input logic il, input logic ordy);
        logic [OW-1:0] col;
        in_valid  = iv;
        in_data   = d;
        in_last   = il;
        out_ready = ordy;
        @(negedge clk);
        s_in_ready  = in_ready;
        s_out_valid = out_valid;
        s_out_last  = out_last;
        s_out_data  = out_data;
        s_err       = err_frame;
        in_fire     = iv && s_in_ready;
        if (s_out_valid && ordy) begin
            out_beats++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_beat: got %h expected no beat", s_out_data);
            end else begin
                chk("sb_data", s_out_data, exp_q.pop_front());
                chk("sb_last", OW'(s_out_last), OW'(exp_last_q.pop_front()));
            end
        end
        if (in_fire) begin
            mrows[mcnt] = d;
            mcnt++;
            if (mcnt == ROWS) begin
                for (int c = 0; c < COLS; c++) begin
                    col = '0;
                    for (int r = 0; r < ROWS; r++) begin
                        col[r*DATA_W +: DATA_W] = mrows[r][c*DATA_W +: DATA_W];
                    end
                    exp_q.push_back(col);
                    exp_last_q.push_back(c == COLS - 1);
                end
                mcnt = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        chk("rst_in_ready", OW'(in_ready), OW'(1));
        chk("rst_out_valid", OW'(out_valid), OW'(0));
        chk("rst_out_last", OW'(out_last), OW'(0));
        chk("rst_err_frame", OW'(err_frame), OW'(0));
        mcnt = 0;
        exp_q.delete();
        exp_last_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int low;
        int sent;

        vecs[0] = '{1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0};
        vecs[1] = '{1'b1, 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0};
        vecs[2] = '{1'b1, 2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0};
        vecs[3] = '{1'b1, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0};
        vecs[4] = '{1'b0, 0, 1'b0, 1'b1, PP,   1'b1, 1'b0, 64'h0030_0020_0010_0000, 1'b0};
        vecs[5] = '{1'b0, 0, 1'b0, 1'b1, PP,   1'b1, 1'b0, 64'h0031_0021_0011_0001, 1'b0};
        vecs[6] = '{1'b0, 0, 1'b0, 1'b1, PP,   1'b1, 1'b1, 64'h0032_0022_0012_0002, 1'b0};
        vecs[7] = '{1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0};

        rst_n = 1'b1;
        #2;
        do_reset();

        // Single tile, table driven.
        for (int i = 0; i < 8; i++) begin
            cycle(vecs[i].iv, row_data(0, vecs[i].row), vecs[i].il, vecs[i].ordy);
            chk($sformatf("v%0d_in_ready", i), OW'(s_in_ready), OW'(vecs[i].x_in_ready));
            chk($sformatf("v%0d_out_valid", i), OW'(s_out_valid), OW'(vecs[i].x_out_valid));
            chk($sformatf("v%0d_out_last", i), OW'(s_out_last), OW'(vecs[i].x_out_last));
            chk($sformatf("v%0d_err", i), OW'(s_err), OW'(vecs[i].x_err));
            if (vecs[i].x_out_valid) begin
                chk($sformatf("v%0d_out_data", i), s_out_data, vecs[i].x_out_data);
            end
        end

        // Output backpressure mid-drain.
        for (int r = 0; r < ROWS; r++) cycle(1'b1, row_data(1, r), r == ROWS - 1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, '0, 1'b0, 1'b0);
            chk("bp_valid", OW'(s_out_valid), OW'(1));
            chk("bp_data", s_out_data, 64'h0131_0121_0111_0101);
            chk("bp_last", OW'(s_out_last), OW'(0));
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        chk("bp_idle_valid", OW'(s_out_valid), OW'(0));
        chk("bp_queue_empty", OW'(exp_q.size()), OW'(0));

        // Back-to-back tiles 2..5 with continuous valid/ready.
        n = 0;
        low = 0;
        sent = 0;
        while (!(sent == 4 * ROWS && exp_q.size() == 0) && n < 100) begin
            cycle(sent < 4 * ROWS, row_data(2 + sent / ROWS, sent % ROWS),
                  (sent % ROWS) == ROWS - 1, 1'b1);
            if (!s_in_ready) low++;
            if (in_fire) sent++;
            n++;
        end
        chk("b2b_cycles", OW'(n), PP ? OW'(19) : OW'(28));
        chk("b2b_in_ready_low", OW'(low), PP ? OW'(0) : OW'(12));

        // Framing error: in_last on row 1.
        for (int r = 0; r < ROWS; r++) begin
            cycle(1'b1, row_data(6, r), r == 1, 1'b1);
            chk($sformatf("frm_err_r%0d", r), OW'(s_err), (r >= 2) ? OW'(1) : OW'(0));
        end
        for (int k = 0; k < COLS + 1; k++) cycle(1'b0, '0, 1'b0, 1'b1);
        chk("frm_err_held", OW'(s_err), OW'(1));
        chk("frm_queue_empty", OW'(exp_q.size()), OW'(0));

        // Reset after two rows, then a clean tile.
        cycle(1'b1, row_data(7, 0), 1'b0, 1'b1);
        cycle(1'b1, row_data(7, 1), 1'b0, 1'b1);
        do_reset();
        for (int r = 0; r < ROWS; r++) cycle(1'b1, row_data(8, r), r == ROWS - 1, 1'b1);
        for (int k = 0; k < COLS + 1; k++) cycle(1'b0, '0, 1'b0, 1'b1);
        chk("rst_tile_queue_empty", OW'(exp_q.size()), OW'(0));
        chk("rst_tile_err", OW'(s_err), OW'(0));

        // Random throttling over 50 tiles.
        n = 0;
        sent = 0;
        out_beats = 0;
        while (!(sent == 50 * ROWS && exp_q.size() == 0) && n < 20000) begin
            cycle((sent < 50 * ROWS) && ($urandom_range(3) != 0),
                  row_data(10 + sent / ROWS, sent % ROWS),
                  (sent % ROWS) == ROWS - 1, $urandom_range(2) != 0);
            if (in_fire) sent++;
            n++;
        end
        chk("rand_rows_sent", OW'(sent), OW'(50 * ROWS));
        chk("rand_queue_empty", OW'(exp_q.size()), OW'(0));
        chk("rand_beats", OW'(out_beats), OW'(50 * COLS));
        chk("rand_err", OW'(s_err), OW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
